// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DATA arbiter and latency sequencer for the unified memory port
// One access at a time: IDLE picks a winner, ACCESS holds the memory for LATENCY cycles, RESP pulses.
module mem_port_arbiter #(
  parameter int LATENCY       = 2,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_resp,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  output logic        d_resp,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;   // 1 = DATA won last, 0 = IF won last
  logic        win_q, win_d;     // requester owning the current access, same encoding
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        grant_d;

  assign rdata = rdata_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win_d     = win_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    grant_d   = 1'b0;
    if_resp   = 1'b0;
    d_resp    = 1'b0;
    busy      = (state_q != S_IDLE);
    mem_addr  = 32'd0;
    mem_din   = 32'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          // Under contention without priority, the side that did not win last time goes.
          grant_d = d_req && (!if_req || DATA_PRIORITY || !last_q);
          win_d   = grant_d;
          last_d  = grant_d;
          addr_d  = grant_d ? d_addr : if_addr;
          wdata_d = grant_d ? d_wdata : 32'd0;
          we_d    = grant_d && d_we;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_addr  = addr_q;
        mem_din   = wdata_q;
        mem_read  = !we_q;
        mem_write = we_q && (cnt_q == 4'd0);
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = mem_dout;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if_resp = !win_q;
        d_resp  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A reset cycle that lands on the final write cycle must not commit the write.
    if (reset) begin
      if_resp   = 1'b0;
      d_resp    = 1'b0;
      busy      = 1'b0;
      mem_addr  = 32'd0;
      mem_din   = 32'd0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port unified memory (async read, sync write, word-addressed internally by addr>>2).
- Shares that memory between the instruction-fetch port (IF) and the load/store port (DATA) of the multi-cycle CPU.
- Serialises accesses, models a configurable access latency and returns one response per granted request.

Parameters:
LATENCY, 2, memory-side cycles per access; legal range 1..15.
DATA_PRIORITY, 1, 1 = DATA always wins a simultaneous request; 0 = round-robin between IF and DATA.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
if_req  input  1  IF request; held with if_addr stable until if_resp
if_addr  input  32  IF byte address
if_resp  output  1  one-cycle pulse: IF access complete, rdata valid
d_req  input  1  DATA request; held with d_addr/d_wdata/d_we stable until d_resp
d_addr  input  32  DATA byte address
d_wdata  input  32  DATA write data
d_we  input  1  1 = write, 0 = read
d_resp  output  1  one-cycle pulse: DATA access complete
rdata  output  32  read data registered for the current response
busy  output  1  1 when state != IDLE
mem_addr  output  32  to memory addr
mem_din  output  32  to memory din
mem_read  output  1  to memory mem_read
mem_write  output  1  to memory mem_write
mem_dout  input  32  from memory dout

Behaviour:
- Reset (synchronous): state=IDLE, counter=0, last_winner=DATA, latched request cleared. All outputs 0: if_resp, d_resp, rdata, busy, mem_addr, mem_din, mem_read, mem_write. mem_write is 0 during every reset cycle.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE. Memory outputs are 0.
  - Any req: choose a winner.
    - Only one requester: that requester wins.
    - Both requesting, DATA_PRIORITY=1: DATA wins.
    - Both requesting, DATA_PRIORITY=0: the requester that is not last_winner wins.
  - On the winning edge: latch the winner's addr/wdata/we (IF is always read), update last_winner, load counter=LATENCY-1, go to ACCESS.
- ACCESS (exactly LATENCY cycles):
  - mem_addr = latched addr. mem_din = latched wdata.
  - Read: mem_read=1 every ACCESS cycle.
  - Write: mem_read=0. mem_write=1 only on the final ACCESS cycle (counter==0), so exactly one write edge per request.
  - Counter decrements each cycle. At counter==0: rdata <= mem_dout for reads; rdata holds its previous value for writes. Go to RESP.
- RESP (one cycle):
  - Winner's resp=1. Memory outputs are 0. Go to IDLE.
- Timing: request accepted at edge t gives resp high during cycle t+LATENCY+1. The earliest next acceptance is the edge ending the cycle after RESP.
- Throughput: one access per LATENCY+2 cycles.
- Requester rules:
  - A req still high in the cycle after its resp is a new request.
  - The losing requester keeps waiting with no timeout.
  - Inputs changing while that port's request is latched are ignored.
- if_resp and d_resp are never high together. Neither is high outside RESP.
- Reset mid-ACCESS: abort, no write is issued on the reset edge, no resp is issued, next cycle is IDLE.
- Addresses pass through unchanged, with no alignment check. Word selection stays in the memory.
- Round-robin (DATA_PRIORITY=0) under continuous contention: grants alternate IF, DATA, IF, ... starting with IF after reset.

Test Plan:
- LATENCY=2; preload mem word 4 = 32'hDEADBEEF; if_req with if_addr=0x10 accepted at edge 0 -> mem_read high for 2 cycles, if_resp pulses in cycle 3 with rdata=0xDEADBEEF, busy low in cycle 4.
- DATA write d_addr=0x20, d_wdata=0x12345678, d_we=1 -> mem_write high for exactly 1 cycle; a following DATA read of 0x20 -> d_resp with rdata=0x12345678.
- DATA_PRIORITY=1, if_req and d_req both held high -> DATA granted on every arbitration and IF starves; dropping d_req -> IF granted next.
- DATA_PRIORITY=0, both held high for 4 grants -> grant order IF, DATA, IF, DATA; resp pulses spaced LATENCY+2 cycles apart.
- Write request in ACCESS, reset asserted on the final ACCESS cycle -> target word unchanged, no resp, outputs 0, IDLE the next cycle.
- LATENCY=1, single read -> resp in the cycle after the single ACCESS cycle; back-to-back reads achieve a 3-cycle period.
